run_packer: RTL



---
 rtl/run_packer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/run_packer.sv
// run_packer: packs sorted single records pairwise into 2*DATA_WIDTH words and
// appends an all-zero terminator after every run. The output side is a small
// first-word-fall-through FIFO that a merger input reads directly.
module run_packer #(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 80,
  parameter int RUN_LOG    = 4,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_valid,
  input  logic                    i_last,
  output logic                    o_ready,
  output logic [2*DATA_WIDTH-1:0] o_data,
  output logic                    o_empty,
  input  logic                    i_read,
  output logic [31:0]             o_runs,
  output logic                    o_error
);

  localparam int PW = (RUN_LOG > 1) ? RUN_LOG - 1 : 1;
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PW-1:0] PAIR_MAX = PW'((1 << (RUN_LOG - 1)) - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(OUT_DEPTH);

  // Catch parameter sets the datapath cannot represent.
  if (KEY_WIDTH < 1 || KEY_WIDTH > DATA_WIDTH) begin : g_bad_key
    $error("run_packer: KEY_WIDTH must lie in 1..DATA_WIDTH");
  end
  if (RUN_LOG < 1 || OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("run_packer: RUN_LOG >= 1 and OUT_DEPTH a power of two >= 2");
  end

  typedef enum logic [1:0] {LO, HI, TERM} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic [PW-1:0]           pair_q;
  logic [31:0]             runs_q;
  logic                    err_q;
  logic [2*DATA_WIDTH-1:0] mem [OUT_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;

  logic                    full, accept, deq;
  logic                    enq, term, pair_inc;
  logic [2*DATA_WIDTH-1:0] enq_data;

  // Readiness uses only registered state so a same-cycle read cannot unblock input.
  assign full    = (count == DEPTH_C);
  assign o_ready = ~i_rst & (state_q != TERM) & ~full;
  assign accept  = i_valid & o_ready;
  assign deq     = i_read & (count != '0);

  assign o_empty = (count == '0);
  assign o_data  = o_empty ? '0 : mem[rd_ptr];
  assign o_runs  = runs_q;
  assign o_error = err_q;

  // Next-state and enqueue decode.
  always_comb begin
    state_d  = state_q;
    enq      = 1'b0;
    enq_data = '0;
    term     = 1'b0;
    pair_inc = 1'b0;
    case (state_q)
      LO: if (accept) state_d = HI;
      HI: if (accept) begin
        enq      = 1'b1;
        enq_data = {i_data, lo_q};
        pair_inc = 1'b1;
        state_d  = (pair_q == PAIR_MAX || i_last) ? TERM : LO;
      end
      TERM: if (!full) begin
        enq     = 1'b1;
        term    = 1'b1;
        state_d = LO;
      end
      default: state_d = LO;
    endcase
  end

  // FSM, low-half latch, pair/run counters and sticky error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= LO;
      lo_q    <= '0;
      pair_q  <= '0;
      runs_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == LO) lo_q <= i_data;
      if (term)          pair_q <= '0;
      else if (pair_inc) pair_q <= pair_q + 1'b1;
      if (term) runs_q <= runs_q + 32'd1;
      // Zero is reserved for the terminator; i_last on a first record is malformed.
      if (accept && ((state_q == LO && i_last) || i_data == '0)) err_q <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; enqueue never happens while full.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; entries are only read once written, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (enq) mem[wr_ptr] <= enq_data;
  end

endmodule
